// File: rtl/pe_collect.sv
// pe_collect -- ping-pong frame collector.
//
// Gathers four parallel butterfly result lanes per beat into one of two
// N-sample banks, then streams a completed bank out one sample per cycle
// through a registered valid/ready output. While one bank drains, the other
// fills, so back-to-back frames flow without bubbles as long as the
// consumer keeps pace.
//
// Build option:
//   PE_COLLECT_BITREV_EN  - when defined, the drain order is the LOG2N-bit
//                           bit-reversal of the read counter (FFT output
//                           reordering); otherwise natural order.

module pe_collect #(
    parameter int WIDTH = 16,
    parameter int LOG2N = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             overflow
);

    localparam int N      = 1 << LOG2N;
    localparam int NBEATS = N / 4;
    // Beat counter needs LOG2N-2 bits; keep at least one bit so LOG2N = 2
    // still elaborates (the counter then simply stays at zero).
    localparam int BW     = (LOG2N > 2) ? LOG2N - 2 : 1;

    localparam logic [BW-1:0]    LAST_BEAT   = BW'(NBEATS - 1);
    localparam logic [LOG2N-1:0] LAST_SAMPLE = LOG2N'(N - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem [2*N];      // {bank, sample index}
    logic [1:0]       full;           // bank holds a complete frame
    logic [1:0]       full_nxt;
    logic             wb;             // bank being written
    logic             rb;             // bank being read
    logic [BW-1:0]    wcnt;           // beat index within the write frame
    logic [LOG2N-1:0] rcnt;           // next sample index to load from rb

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic             wr_accept;
    logic             wr_drop;
    logic             wr_frame_done;
    logic [LOG2N-1:0] wr_base;

    assign in_ready      = !full[wb];
    assign wr_accept     = in_valid && in_ready;
    assign wr_drop       = in_valid && !in_ready;
    assign wr_frame_done = wr_accept && (wcnt == LAST_BEAT);
    // Beat k covers samples 4k..4k+3; low two address bits select the lane.
    assign wr_base       = LOG2N'(wcnt) << 2;

    // Bank storage: the four lanes of a beat land in consecutive samples.
    // NOTE: the sample array is deliberately left out of reset; a frame is
    // only ever read after it has been completely written, so stale contents
    // are never observed and the array can map onto plain RAM.
    always_ff @(posedge Clk) begin
        if (wr_accept) begin
            mem[{wb, wr_base | LOG2N'(0)}] <= in0;
            mem[{wb, wr_base | LOG2N'(1)}] <= in1;
            mem[{wb, wr_base | LOG2N'(2)}] <= in2;
            mem[{wb, wr_base | LOG2N'(3)}] <= in3;
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    logic             acc_last;       // final sample of rb leaves this edge
    logic             avail;          // a sample is ready to be loaded
    logic             load;           // output register takes a new sample
    logic             sel_bank;       // bank the next sample comes from
    logic [LOG2N-1:0] sel_r;          // read counter for the next sample
    logic [LOG2N-1:0] rd_addr;        // sample index within sel_bank

    // Pick the source of the next output sample; on the edge that retires a
    // frame, look straight into the other bank so no bubble is inserted.
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so evaluation order is explicit and no latch is
    // inferred; clocked blocks use non-blocking '<=' only.
    always_comb begin
        acc_last = out_valid && out_ready && out_last;
        sel_bank = rb;
        sel_r    = rcnt;
        // Once sample N-1 sits in the output register the bank has nothing
        // more to give until that sample is accepted.
        avail    = full[rb] && !(out_valid && out_last);
        if (acc_last) begin
            sel_bank = ~rb;
            sel_r    = '0;
            avail    = full[~rb];
        end
        load = (!out_valid || out_ready) && avail;
    end

`ifdef PE_COLLECT_BITREV_EN
    // Bit-reversed drain order.
    always_comb begin
        rd_addr = '0;
        for (int i = 0; i < LOG2N; i++) begin
            rd_addr[i] = sel_r[LOG2N-1-i];
        end
    end
`else
    // Natural drain order.
    always_comb begin
        rd_addr = sel_r;
    end
`endif

    // Registered output stage: load on a free or draining slot, else hold.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            rcnt      <= '0;
        end else if (load) begin
            out_data  <= mem[{sel_bank, rd_addr}];
            out_valid <= 1'b1;
            out_last  <= (sel_r == LAST_SAMPLE);
            // Wraps to zero after sample N-1, ready for the next frame.
            rcnt      <= sel_r + 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (acc_last) begin
                rcnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bank bookkeeping
    // ------------------------------------------------------------------

    // Writer sets its bank full while the reader may clear the other one in
    // the same edge; the two can never target the same bank because the
    // writer only touches an empty bank and the reader only a full one.
    always_comb begin
        full_nxt = full;
        if (wr_frame_done) begin
            full_nxt[wb] = 1'b1;
        end
        if (acc_last) begin
            full_nxt[rb] = 1'b0;
        end
    end

    // Bank flags, bank pointers, beat counter and sticky overflow.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            full     <= '0;
            wb       <= 1'b0;
            rb       <= 1'b0;
            wcnt     <= '0;
            overflow <= 1'b0;
        end else begin
            full <= full_nxt;
            if (wr_accept) begin
                if (wr_frame_done) begin
                    wcnt <= '0;
                    wb   <= ~wb;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
            if (acc_last) begin
                rb <= ~rb;
            end
            if (wr_drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/pe_collect.md
PE_COLLECT -- requirements
Module: pe_collect

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning bit width of each sample lane.
REQ-002 SHALL have parameter LOG2N, default 4, meaning log2 of frame length N; legal range 2..10.
REQ-003 SHALL have port Clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit, meaning asynchronous, active-high reset.
REQ-005 SHALL have ports in0, in1, in2, in3, input, WIDTH bits each, meaning the four parallel butterfly result lanes.
REQ-006 SHALL have port in_valid, input, 1 bit, meaning in0..in3 carry a beat this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit, meaning the write bank can accept a beat.
REQ-008 SHALL have port out_data, output, WIDTH bits, meaning the serial output sample.
REQ-009 SHALL have port out_valid, output, 1 bit, meaning out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit, meaning the downstream consumer accepts out_data.
REQ-011 SHALL have port out_last, output, 1 bit, meaning out_data is sample N-1 of the frame.
REQ-012 SHALL have port overflow, output, 1 bit, meaning sticky flag for a dropped input beat.

Function
REQ-013 SHALL contain two banks (ping-pong), each holding N samples of WIDTH bits, and a full flag per bank.
REQ-014 SHALL accept a beat when in_valid && in_ready; beat k (0..N/4-1) writes lane j to sample index 4k+j of write bank wb.
REQ-015 SHALL drive in_ready = !full[wb], combinationally from registered state.
REQ-016 SHALL, on accepting beat N/4-1, set full[wb] and toggle wb, and reset the beat counter to 0 in the same edge.
REQ-017 SHALL drop a beat presented with in_valid && !in_ready, leave memory and counters unchanged, and set overflow to 1 on the next edge.
REQ-018 SHALL read bank rb while full[rb]; read counter r runs 0..N-1; address = f(r) per REQ-029/REQ-030.
REQ-019 SHALL register the output: load out_data/out_valid/out_last when (!out_valid || out_ready) and a sample remains; otherwise hold all three stable.
REQ-020 SHALL assert out_valid on the first edge after full[rb] becomes 1; from then on it SHALL sustain 1 sample/cycle while out_ready = 1.
REQ-021 SHALL assert out_last exactly with sample r = N-1.
REQ-022 SHALL, when out_last is accepted, clear full[rb], toggle rb and reset r to 0 in the same edge; a full other bank continues with no bubble cycle.
REQ-023 SHALL allow a write-side set and a read-side clear on different banks in the same edge, with both taking effect.
REQ-024 SHALL keep in_ready = 1 continuously for back-to-back frames when output drain keeps pace (out_ready = 1).
REQ-025 SHALL pass samples unmodified (no arithmetic, no truncation).

Reset
REQ-026 SHALL, while Reset = 1, force in_ready=1, out_valid=0, out_last=0, out_data=0, overflow=0, full[1:0]=0, wb=0, rb=0 and all counters to 0, asynchronously.
REQ-027 SHALL discard any partial or pending frame on reset mid-operation; memory contents need not be cleared.
REQ-028 SHALL accept beats starting on the first rising edge after Reset deasserts.

Configuration
REQ-029 SHALL, with macro PE_COLLECT_BITREV_EN defined, set the read address to the LOG2N-bit bit-reversal of r.
REQ-030 SHALL, without PE_COLLECT_BITREV_EN, set the read address to r (natural order); all other behaviour is identical.

Verification (N=16, WIDTH=16)
REQ-031 SHALL cover: 4 beats with values in0..in3 = 4k..4k+3 and out_ready=1 -> out_valid 1 cycle after last beat; with BITREV_EN output order 0,8,4,12,2,10,...,15, without it 0..15; out_last on 16th.
REQ-032 SHALL cover: 3 frames back-to-back with out_ready=1 -> in_ready never low, outputs contiguous, 48 samples with no gap between frames.
REQ-033 SHALL cover: out_ready=0 while 2 frames are written -> in_ready low after 8th beat; 9th beat dropped, overflow=1; after drain, data from frames 1 and 2 is intact.
REQ-034 SHALL cover: out_ready toggling 1,0,1,0 -> out_data held stable while out_ready=0, no sample lost or duplicated.
REQ-035 SHALL cover: Reset pulse after 2 beats and mid-drain -> outputs at reset values immediately; next full frame is output correctly, overflow=0.
